// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the UART-driven instruction loader.
// The checksum option is selected with the INSTR_LOADER_CHECKSUM_EN macro.
package instr_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    // Timeout counter width for a given cycle limit: $clog2(TIMEOUT_CYCLES+1).
    function automatic int timer_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/instr_loader_timer.sv
// Clearable idle-cycle counter; saturates at the limit and reports expiry.
module loader_timer
    import instr_loader_pkg::*;
#(
    parameter int CYCLES = 100000,
    parameter int W      = timer_width(CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [W-1:0] LIMIT = W'(CYCLES - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One cycle short of the limit, so the FSM acts on the edge that reaches it.
    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/instr_loader.sv
// Assembles big-endian words from UART bytes and writes them to instruction RAM,
// holding the CPU while loading. Define INSTR_LOADER_CHECKSUM_EN for an XOR trailer byte.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ROM_SIZE_BIT   = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  start,
    input  logic [ROM_SIZE_BIT:0] word_count,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    localparam int IW = ROM_SIZE_BIT + 1;
    localparam logic [IW-1:0]     FULL_DEPTH = {1'b1, {ROM_SIZE_BIT{1'b0}}};
    localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(BYTES_PER_WORD - 1);

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     r_words;
    logic [BCNT_W-1:0] r_bcnt;
    logic [31:0]       r_asm;
    logic              r_we, r_hold, r_busy, r_done, r_err;
    logic [31:0]       r_addr, r_wdata;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic        w_start, w_byte, w_last, w_expired;
    logic [31:0] w_asm_next, w_addr;

    assign w_start    = start && (r_state == S_IDLE || r_state == S_FINISH);
    assign w_byte     = rx_valid && (r_state == S_RECV || r_state == S_WRITE);
    assign w_last     = (r_idx + IW'(1)) == r_words;
    assign w_asm_next = {r_asm[23:0], rx_data};
    assign w_addr     = {{(32 - IW - 2){1'b0}}, r_idx, 2'b00};

    loader_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_start || w_byte),
        .i_enable (r_state == S_RECV),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_words <= '0;
            r_bcnt  <= '0;
            r_asm   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_words <= (word_count == '0) ? FULL_DEPTH : word_count;
                r_idx   <= '0;
                r_bcnt  <= '0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_busy  <= 1'b1;
                r_hold  <= 1'b1;
                r_state <= S_RECV;
`ifdef INSTR_LOADER_CHECKSUM_EN
                r_csum  <= '0;
`endif
            end else begin
                case (r_state)
                    S_RECV: begin
                        if (rx_valid) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            // All words written: this byte is the XOR trailer.
                            if (r_idx == r_words) begin
                                r_done  <= (r_csum == rx_data);
                                r_err   <= (r_csum != rx_data);
                                r_hold  <= (r_csum != rx_data);
                                r_busy  <= 1'b0;
                                r_state <= S_FINISH;
                            end else begin
                                r_csum <= r_csum ^ rx_data;
`endif
                                r_asm  <= w_asm_next;
                                r_bcnt <= r_bcnt + 1'b1;
                                if (r_bcnt == LAST_BYTE) begin
                                    r_we    <= 1'b1;
                                    r_addr  <= w_addr;
                                    r_wdata <= w_asm_next;
                                    r_state <= S_WRITE;
                                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                            end
`endif
                        end else if (w_expired) begin
                            r_err   <= 1'b1;
                            r_hold  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_FINISH;
                        end
                    end
                    S_WRITE: begin
                        r_idx  <= r_idx + IW'(1);
                        r_bcnt <= '0;
                        if (w_last) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            if (rx_valid) begin
                                r_done  <= (r_csum == rx_data);
                                r_err   <= (r_csum != rx_data);
                                r_hold  <= (r_csum != rx_data);
                                r_busy  <= 1'b0;
                                r_state <= S_FINISH;
                            end else begin
                                r_state <= S_RECV;
                            end
`else
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_hold  <= 1'b0;
                            r_state <= S_FINISH;
`endif
                        end else begin
                            // A strobe here is byte 0 of the next word.
                            if (rx_valid) begin
                                r_asm  <= w_asm_next;
                                r_bcnt <= BCNT_W'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
                                r_csum <= r_csum ^ rx_data;
`endif
                            end
                            r_state <= S_RECV;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_hold  = r_hold;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized checks of instr_loader against a byte-list reference model.
// Checksum-specific steps are compiled in when INSTR_LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

    localparam int RB    = 2;
    localparam int TO    = 20;
    localparam int DEPTH = 1 << RB;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        start;
    logic [RB:0] word_count;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        cpu_hold, busy, done, err;
    logic [1:0]  dbg_state;

    instr_loader #(.ROM_SIZE_BIT(RB), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .start     (start),
        .word_count(word_count),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int   we_double = 0;
    logic prev_we   = 1'b0;

    // Write monitor: records {addr, data} for every write-enable cycle.
    always @(negedge clk) begin
        if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
        if (mem_we && prev_we) we_double++;
        prev_we = mem_we;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int wc);
        word_count = (RB + 1)'(wc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_end(input int bound);
        int k = 0;
        while (!(done || err) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("end_within_bound", 64'(done || err), 64'd1);
    endtask

    task automatic check_writes(input string tag);
        logic [63:0] e, o;
        check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            check(tag, o, e);
        end
        obs_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},    64'(mem_we),    64'd0);
        check({tag, "_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_hold"},  64'(cpu_hold),  64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_done"},  64'(done),      64'd0);
        check({tag, "_err"},   64'(err),       64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // Reference: byte list -> big-endian words at consecutive word addresses.
    task automatic run_random_load(input string tag);
        int wc, n, nb;
        logic [7:0] bytes_q[$];
        logic [7:0] x;
        wc = $urandom_range(0, DEPTH);
        n  = (wc == 0) ? DEPTH : wc;
        nb = 4 * n;
        x  = 8'h00;
        for (int i = 0; i < nb; i++) begin
            bytes_q.push_back(8'($urandom_range(0, 255)));
            x = x ^ bytes_q[i];
        end
        for (int w = 0; w < n; w++)
            exp_q.push_back({32'(4 * w), bytes_q[4*w], bytes_q[4*w+1], bytes_q[4*w+2], bytes_q[4*w+3]});
        pulse_start(wc);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        for (int i = 0; i < nb; i++) send_byte(bytes_q[i], $urandom_range(0, 4));
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(x, 0);
`endif
        wait_end(200);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_err"},  64'(err),  64'd0);
        check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        check_writes(tag);
    endtask

    initial begin
        logic [7:0] x;
        reset = 1'b1; rx_data = '0; rx_valid = 1'b0; start = 1'b0; word_count = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Bytes in IDLE are ignored.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 0);
        check("idle_no_write", 64'(obs_q.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Full-depth load, bytes 00..0F, gap 3.
        exp_q.push_back({32'h0, 32'h00010203});
        exp_q.push_back({32'h4, 32'h04050607});
        exp_q.push_back({32'h8, 32'h08090A0B});
        exp_q.push_back({32'hC, 32'h0C0D0E0F});
        pulse_start(4);
        check("full_busy", 64'(busy), 64'd1);
        check("full_hold", 64'(cpu_hold), 64'd1);
        for (int i = 0; i < 15; i++) send_byte(8'(i), 3);
        send_byte(8'h0F, 0);
        check("full_last_we", 64'(mem_we), 64'd1);
        check("full_last_addr", 64'(mem_addr), 64'hC);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`else
        check("full_done_not_yet", 64'(done), 64'd0);
        @(negedge clk);
        check("full_done_next", 64'(done), 64'd1);
`endif
        wait_end(50);
        check("full_done", 64'(done), 64'd1);
        check("full_hold_off", 64'(cpu_hold), 64'd0);
        check("full_busy_off", 64'(busy), 64'd0);
        check_writes("full");

        // Back-to-back strobes AA..B1, two words.
        exp_q.push_back({32'h0, 32'hAAABACAD});
        exp_q.push_back({32'h4, 32'hAEAFB0B1});
        pulse_start(2);
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'hAA + i), 0);
            x = x ^ 8'(8'hAA + i);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(x, 0);
`endif
        wait_end(50);
        check("b2b_done", 64'(done), 64'd1);
        check_writes("b2b");
        check("we_single_cycle", 64'(we_double), 64'd0);

        // Timeout: two bytes then silence.
        pulse_start(1);
        send_byte(8'h11, 15);
        send_byte(8'h22, 0);
        repeat (TO - 1) @(negedge clk);
        check("to_err_early", 64'(err), 64'd0);
        check("to_busy_early", 64'(busy), 64'd1);
        @(negedge clk);
        check("to_err", 64'(err), 64'd1);
        check("to_done", 64'(done), 64'd0);
        check("to_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("to_hold", 64'(cpu_hold), 64'd1);
        check("to_no_write", 64'(obs_q.size()), 64'd0);

        // Start during RECV is ignored; a good load also releases the hold.
        exp_q.push_back({32'h0, 32'h31323334});
        exp_q.push_back({32'h4, 32'h35363738});
        pulse_start(2);
        send_byte(8'h31, 1);
        send_byte(8'h32, 1);
        pulse_start(1);
        x = 8'h31 ^ 8'h32;
        for (int i = 3; i <= 8; i++) begin
            send_byte(8'(8'h30 + i), 1);
            x = x ^ 8'(8'h30 + i);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(x, 0);
`endif
        wait_end(50);
        check("ign_done", 64'(done), 64'd1);
        check("ign_hold", 64'(cpu_hold), 64'd0);
        check_writes("ign");

        // Reset mid-load: first word stays written, outputs clear at once.
        exp_q.push_back({32'h0, 32'h41424344});
        pulse_start(2);
        for (int i = 1; i <= 5; i++) send_byte(8'(8'h40 + i), 1);
        #2 reset = 1'b1;
        #1 check_idle_outputs("midreset");
        check_writes("midreset");
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back({32'h0, 32'h51525354});
        pulse_start(1);
        for (int i = 1; i <= 4; i++) send_byte(8'(8'h50 + i), 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h51 ^ 8'h52 ^ 8'h53 ^ 8'h54, 0);
`endif
        wait_end(50);
        check("after_reset_done", 64'(done), 64'd1);
        check_writes("after_reset");

        // Randomized loads; stray bytes in FINISH must not write.
        for (int t = 0; t < 6; t++) begin
            run_random_load($sformatf("rand%0d", t));
            send_byte(8'($urandom_range(0, 255)), 0);
            send_byte(8'($urandom_range(0, 255)), 1);
            check("finish_no_write", 64'(obs_q.size()), 64'd0);
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Checksum trailer: match then mismatch.
        for (int t = 0; t < 2; t++) begin
            exp_q.push_back({32'h0, 32'h01020304});
            pulse_start(1);
            for (int i = 1; i <= 4; i++) send_byte(8'(i), 1);
            send_byte((t == 0) ? 8'h04 : 8'h05, 0);
            wait_end(50);
            check("cs_done", 64'(done), (t == 0) ? 64'd1 : 64'd0);
            check("cs_err",  64'(err),  (t == 0) ? 64'd0 : 64'd1);
            check_writes("cs");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
